// File: rtl/dist_2_af_avlstrm.sv
// rtl/dist_2_af_avlstrm.sv - 1-to-2 round-robin stream distributor with input FIFO and almost-full gating
// Optional delivered-item counters are built when DIST_2_STATS_EN is defined.
module dist_2_af_avlstrm #(
    parameter int DWIDTH     = 8,
    parameter int DEPTH      = 1024,
    parameter int FULL_LEVEL = 800
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              in_almost_full,

    output logic [DWIDTH-1:0] out_data_0,
    output logic              out_valid_0,
    input  logic              out_ready_0,
    input  logic              out_almost_full_0,

    output logic [DWIDTH-1:0] out_data_1,
    output logic              out_valid_1,
    input  logic              out_ready_1,
    input  logic              out_almost_full_1,

    output logic [31:0]       stats_cnt_0,
    output logic [31:0]       stats_cnt_1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_C  = CW'(FULL_LEVEL);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [DWIDTH-1:0] head;
    logic              rr;

    logic push;
    logic pop;
    logic fifo_nonempty;
    logic slot_free_0;
    logic slot_free_1;
    logic eligible_0;
    logic eligible_1;
    logic load_0;
    logic load_1;
    logic rr_advance;

    // No write-through: a full FIFO refuses input even if it pops this cycle.
    assign in_ready      = (count < DEPTH_C) && !rst;
    assign push          = in_valid && in_ready;
    assign fifo_nonempty = (count != '0);
    assign head          = mem[rd_ptr];

    assign slot_free_0 = !out_valid_0 || out_ready_0;
    assign slot_free_1 = !out_valid_1 || out_ready_1;
    assign eligible_0  = slot_free_0 && !out_almost_full_0;
    assign eligible_1  = slot_free_1 && !out_almost_full_1;

    // Preferred port first; a skipped port keeps priority for the next item.
    always_comb begin
        load_0     = 1'b0;
        load_1     = 1'b0;
        rr_advance = 1'b0;
        if (fifo_nonempty) begin
            if (!rr) begin
                if (eligible_0) begin
                    load_0     = 1'b1;
                    rr_advance = 1'b1;
                end else if (eligible_1) begin
                    load_1     = 1'b1;
                end
            end else begin
                if (eligible_1) begin
                    load_1     = 1'b1;
                    rr_advance = 1'b1;
                end else if (eligible_0) begin
                    load_0     = 1'b1;
                end
            end
        end
    end

    assign pop = load_0 || load_1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Flag follows count by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_almost_full <= 1'b0;
        end else begin
            in_almost_full <= (count >= FULL_C);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (rr_advance) begin
            rr <= ~rr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_0 <= 1'b0;
            out_data_0  <= '0;
        end else if (load_0) begin
            out_valid_0 <= 1'b1;
            out_data_0  <= head;
        end else if (out_ready_0) begin
            out_valid_0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_1 <= 1'b0;
            out_data_1  <= '0;
        end else if (load_1) begin
            out_valid_1 <= 1'b1;
            out_data_1  <= head;
        end else if (out_ready_1) begin
            out_valid_1 <= 1'b0;
        end
    end

`ifdef DIST_2_STATS_EN
    logic [31:0] stats_0;
    logic [31:0] stats_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stats_0 <= '0;
            stats_1 <= '0;
        end else begin
            if (out_valid_0 && out_ready_0) begin
                stats_0 <= stats_0 + 32'd1;
            end
            if (out_valid_1 && out_ready_1) begin
                stats_1 <= stats_1 + 32'd1;
            end
        end
    end

    assign stats_cnt_0 = stats_0;
    assign stats_cnt_1 = stats_1;
`else
    assign stats_cnt_0 = 32'd0;
    assign stats_cnt_1 = 32'd0;
`endif

endmodule

// File: tb/tb_dist_2_af_avlstrm.sv
// tb/tb_dist_2_af_avlstrm.sv - scoreboard bench for dist_2_af_avlstrm
module tb_dist_2_af_avlstrm;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int FL    = 10;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          in_almost_full;
    logic [DW-1:0] out_data_0;
    logic          out_valid_0;
    logic          out_ready_0;
    logic          out_almost_full_0;
    logic [DW-1:0] out_data_1;
    logic          out_valid_1;
    logic          out_ready_1;
    logic          out_almost_full_1;
    logic [31:0]   stats_cnt_0;
    logic [31:0]   stats_cnt_1;

    dist_2_af_avlstrm #(.DWIDTH(DW), .DEPTH(DEPTH), .FULL_LEVEL(FL)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_almost_full(in_almost_full),
        .out_data_0(out_data_0), .out_valid_0(out_valid_0),
        .out_ready_0(out_ready_0), .out_almost_full_0(out_almost_full_0),
        .out_data_1(out_data_1), .out_valid_1(out_valid_1),
        .out_ready_1(out_ready_1), .out_almost_full_1(out_almost_full_1),
        .stats_cnt_0(stats_cnt_0), .stats_cnt_1(stats_cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Monitor only records; tasks read with their own indices.
    int   got0[$];
    int   got1[$];
    int   n_pushed = 0;
    int   exp0[$];
    int   exp1[$];
    int   base0;
    int   base1;
    int   base_push;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_0 && out_ready_0) got0.push_back(int'(out_data_0));
            if (out_valid_1 && out_ready_1) got1.push_back(int'(out_data_1));
            if (in_valid && in_ready) n_pushed++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        base0 = got0.size();
        base1 = got1.size();
        base_push = n_pushed;
        exp0.delete();
        exp1.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready_0 = 1'b1;
        out_ready_1 = 1'b1;
        out_almost_full_0 = 1'b0;
        out_almost_full_1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready got %0b want 0", in_ready);
        end
        vectors++;
        if ({out_valid_0, out_valid_1, in_almost_full} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags got %b want 000", {out_valid_0, out_valid_1, in_almost_full});
        end
        vectors++;
        if ({out_data_0, out_data_1} !== '0 || stats_cnt_0 !== 32'd0 || stats_cnt_1 !== 32'd0) begin
            miscompares++; $display("FAIL reset_data got %h/%h/%0d/%0d want 0", out_data_0, out_data_1, stats_cnt_0, stats_cnt_1);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL post_reset_in_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready_0 = 1'b1;
        out_ready_1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            if (i % 2 == 0) exp0.push_back(i); else exp1.push_back(i);
            @(posedge clk);
            #1;
            if (i == 0) begin
                vectors++;
                if (out_valid_0 !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_latency_early got %0b want 0", out_valid_0);
                end
            end
            if (i == 1) begin
                vectors++;
                if (out_valid_0 !== 1'b1 || out_data_0 !== 8'd0) begin
                    miscompares++; $display("FAIL b2b_latency got v=%0b d=%0d want v=1 d=0", out_valid_0, out_data_0);
                end
            end
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (got0.size() - base0 != exp0.size() || got1.size() - base1 != exp1.size()) begin
            miscompares++; $display("FAIL b2b_counts got %0d/%0d want %0d/%0d", got0.size() - base0, got1.size() - base1, exp0.size(), exp1.size());
        end
        for (int j = 0; j < exp0.size(); j++) begin
            vectors++;
            if (base0 + j >= got0.size() || got0[base0 + j] != exp0[j]) begin
                miscompares++; $display("FAIL b2b_port0[%0d] got %0d want %0d", j, (base0 + j < got0.size()) ? got0[base0 + j] : -1, exp0[j]);
            end
        end
        for (int j = 0; j < exp1.size(); j++) begin
            vectors++;
            if (base1 + j >= got1.size() || got1[base1 + j] != exp1[j]) begin
                miscompares++; $display("FAIL b2b_port1[%0d] got %0d want %0d", j, (base1 + j < got1.size()) ? got1[base1 + j] : -1, exp1[j]);
            end
        end
    endtask

    task automatic test_almost_full_skip();
        do_reset();
        out_ready_0 = 1'b1;
        out_ready_1 = 1'b1;
        out_almost_full_1 = 1'b1;
        for (int i = 10; i < 16; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            exp0.push_back(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_almost_full_1 = 1'b0;
        for (int i = 16; i < 18; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            if (i == 16) exp1.push_back(i); else exp0.push_back(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (got0.size() - base0 != exp0.size() || got1.size() - base1 != exp1.size()) begin
            miscompares++; $display("FAIL af_counts got %0d/%0d want %0d/%0d", got0.size() - base0, got1.size() - base1, exp0.size(), exp1.size());
        end
        for (int j = 0; j < exp0.size(); j++) begin
            vectors++;
            if (base0 + j >= got0.size() || got0[base0 + j] != exp0[j]) begin
                miscompares++; $display("FAIL af_port0[%0d] got %0d want %0d", j, (base0 + j < got0.size()) ? got0[base0 + j] : -1, exp0[j]);
            end
        end
        vectors++;
        if (base1 >= got1.size() || got1[base1] != 16) begin
            miscompares++; $display("FAIL af_port1_first got %0d want 16", (base1 < got1.size()) ? got1[base1] : -1);
        end
    endtask

    task automatic test_fill();
        int  mcnt;
        int  held;
        bit  p;
        bit  q;
        bit  af_exp;
        do_reset();
        out_ready_0 = 1'b0;
        out_ready_1 = 1'b0;
        mcnt = 0;
        held = 0;
        for (int n = 0; n < DEPTH + 6; n++) begin
            in_valid = 1'b1;
            in_data = DW'(100 + n_pushed - base_push);
            p = (mcnt < DEPTH);
            q = (mcnt > 0) && (held < 2);
            @(posedge clk);
            #1;
            af_exp = (mcnt >= FL);
            mcnt = mcnt + int'(p) - int'(q);
            held = held + int'(q);
            vectors++;
            if (in_ready !== (mcnt < DEPTH)) begin
                miscompares++; $display("FAIL fill_in_ready[%0d] got %0b want %0b", n, in_ready, mcnt < DEPTH);
            end
            vectors++;
            if (in_almost_full !== af_exp) begin
                miscompares++; $display("FAIL fill_almost_full[%0d] got %0b want %0b", n, in_almost_full, af_exp);
            end
            if (held >= 1) begin
                vectors++;
                if (out_valid_0 !== 1'b1 || out_data_0 !== 8'd100) begin
                    miscompares++; $display("FAIL fill_port0_hold[%0d] got v=%0b d=%0d want v=1 d=100", n, out_valid_0, out_data_0);
                end
            end
            if (held >= 2) begin
                vectors++;
                if (out_valid_1 !== 1'b1 || out_data_1 !== 8'd101) begin
                    miscompares++; $display("FAIL fill_port1_hold[%0d] got v=%0b d=%0d want v=1 d=101", n, out_valid_1, out_data_1);
                end
            end
        end
    endtask

    task automatic test_full_release();
        bit seen [256];
        int total;
        int prev;
        int v;
        out_ready_0 = 1'b1;
        out_ready_1 = 1'b1;
        for (int n = 0; n < 20; n++) begin
            in_data = DW'(100 + n_pushed - base_push);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (DEPTH + 10) @(posedge clk);
        #1;
        total = n_pushed - base_push;
        vectors++;
        if (total != DEPTH + 21) begin
            miscompares++; $display("FAIL release_pushed got %0d want %0d", total, DEPTH + 21);
        end
        vectors++;
        if ((got0.size() - base0) + (got1.size() - base1) != total) begin
            miscompares++; $display("FAIL release_delivered got %0d want %0d", (got0.size() - base0) + (got1.size() - base1), total);
        end
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        prev = -1;
        for (int j = base0; j < got0.size(); j++) begin
            v = got0[j];
            vectors++;
            if (v < 100 || v >= 100 + total || seen[v] || v <= prev) begin
                miscompares++; $display("FAIL release_port0_item got %0d want new in-order value after %0d", v, prev);
            end
            if (v >= 0 && v < 256) seen[v] = 1'b1;
            prev = v;
        end
        prev = -1;
        for (int j = base1; j < got1.size(); j++) begin
            v = got1[j];
            vectors++;
            if (v < 100 || v >= 100 + total || seen[v] || v <= prev) begin
                miscompares++; $display("FAIL release_port1_item got %0d want new in-order value after %0d", v, prev);
            end
            if (v >= 0 && v < 256) seen[v] = 1'b1;
            prev = v;
        end
    endtask

    task automatic test_reset_mid_stream();
        int b0;
        int b1;
        do_reset();
        out_ready_0 = 1'b0;
        out_ready_1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data = DW'(200 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid_0, out_valid_1, in_almost_full, in_ready} !== 4'b0000 || {out_data_0, out_data_1} !== '0) begin
            miscompares++; $display("FAIL midrst_outputs got %b %h %h want 0000 00 00", {out_valid_0, out_valid_1, in_almost_full, in_ready}, out_data_0, out_data_1);
        end
        rst = 1'b0;
        #1;
        b0 = got0.size();
        b1 = got1.size();
        out_ready_0 = 1'b1;
        out_ready_1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if (got0.size() != b0 || got1.size() != b1 || out_valid_0 !== 1'b0 || out_valid_1 !== 1'b0) begin
            miscompares++; $display("FAIL midrst_stale got %0d/%0d items want 0/0", got0.size() - b0, got1.size() - b1);
        end
    endtask

    task automatic test_stats();
        int want;
        do_reset();
        out_ready_0 = 1'b1;
        out_ready_1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data = DW'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
`ifdef DIST_2_STATS_EN
        want = 50;
`else
        want = 0;
`endif
        vectors++;
        if (stats_cnt_0 !== 32'(want)) begin
            miscompares++; $display("FAIL stats_cnt_0 got %0d want %0d", stats_cnt_0, want);
        end
        vectors++;
        if (stats_cnt_1 !== 32'(want)) begin
            miscompares++; $display("FAIL stats_cnt_1 got %0d want %0d", stats_cnt_1, want);
        end
        vectors++;
        if (got0.size() - base0 != 50 || got1.size() - base1 != 50) begin
            miscompares++; $display("FAIL stats_split got %0d/%0d want 50/50", got0.size() - base0, got1.size() - base1);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready_0 = 1'b0;
        out_ready_1 = 1'b0;
        out_almost_full_0 = 1'b0;
        out_almost_full_1 = 1'b0;
        test_reset();
        test_back_to_back();
        test_almost_full_skip();
        test_fill();
        test_full_release();
        test_reset_mid_stream();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
